// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: synchronises raw sources, latches edge/level
// requests, applies mask and fixed priority with in-service nesting, and drives HWInt.
module int_ctrl #(
  parameter int NSRC        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE,
  input  logic             RE,
  input  logic [29:0]      Addr,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [NSRC-1:0]  src,
  output logic [NSRC-1:0]  HWInt,
  output logic             irq
);

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_MASK    = 3'd1;
  localparam logic [2:0] OFF_MODE    = 3'd2;
  localparam logic [2:0] OFF_CLEAR   = 3'd3;
  localparam logic [2:0] OFF_CLAIM   = 3'd4;
  localparam logic [2:0] OFF_EOI     = 3'd5;
  localparam logic [2:0] OFF_INSVC   = 3'd6;

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] sync_d [SYNC_STAGES];
  logic [NSRC-1:0] prev_q, prev_d;
  logic [NSRC-1:0] edge_pend_q, edge_pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] insvc_q, insvc_d;

  logic [2:0]      offset_s;
  logic            wr_mask_s, wr_mode_s, wr_clear_s, wr_eoi_s, rd_claim_s;
  logic [NSRC-1:0] s_sync_s;
  logic [NSRC-1:0] pending_s;
  logic [NSRC-1:0] below_s;
  logic            seen_s;
  logic [NSRC-1:0] hwint_s;
  logic            claim_valid_s;
  logic [2:0]      claim_id_s;
  logic            found_s;
  logic            claim_fire_s;
  logic [NSRC-1:0] claim_onehot_s;
  logic [NSRC-1:0] eoi_onehot_s;
  logic [NSRC-1:0] rise_s;
  logic [NSRC-1:0] clr_s;
  logic [NSRC-1:0] mode_chg_s;
  logic            unused_s;

  assign offset_s   = Addr[2:0];
  assign wr_mask_s  = WE && (offset_s == OFF_MASK);
  assign wr_mode_s  = WE && (offset_s == OFF_MODE);
  assign wr_clear_s = WE && (offset_s == OFF_CLEAR);
  assign wr_eoi_s   = WE && (offset_s == OFF_EOI);
  assign rd_claim_s = RE && (offset_s == OFF_CLAIM);
  assign s_sync_s   = sync_q[SYNC_STAGES-1];
  assign unused_s   = ^{Addr[29:3], Din[31:NSRC]};

  // Synchroniser chain: stage 0 samples the raw pins, later stages shift.
  always_comb begin
    for (int s = 0; s < SYNC_STAGES; s++) begin
      if (s == 0) begin
        sync_d[s] = src;
      end else begin
        sync_d[s] = sync_q[s-1];
      end
    end
  end

  // Visible request vector: edge bits come from the latch, level bits straight from the synchroniser.
  always_comb begin
    pending_s = (mode_q & edge_pend_q) | (~mode_q & s_sync_s);
  end

  // Priority ceiling: a source is eligible only if no bit at or above its priority is in service.
  always_comb begin
    seen_s  = 1'b0;
    below_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      seen_s     = seen_s | insvc_q[i];
      below_s[i] = ~seen_s;
    end
  end

  assign hwint_s       = pending_s & mask_q & below_s;
  assign claim_valid_s = |hwint_s;

  // Lowest-index eligible source is the one software will claim.
  always_comb begin
    claim_id_s = 3'd0;
    found_s    = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hwint_s[i] && !found_s) begin
        claim_id_s = 3'(i);
        found_s    = 1'b1;
      end else begin
        found_s    = found_s;
      end
    end
  end

  assign claim_fire_s = rd_claim_s && claim_valid_s;

  // One-hot decodes of the claimed id and the retired id; EOI ids beyond NSRC match nothing.
  always_comb begin
    claim_onehot_s = '0;
    eoi_onehot_s   = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_onehot_s[i] = claim_fire_s && (claim_id_s == 3'(i));
      eoi_onehot_s[i]   = wr_eoi_s && (Din[2:0] == 3'(i));
    end
  end

  // Next-state for edge latch, mask, mode and in-service; a new edge beats any clear on the same edge.
  always_comb begin
    prev_d = s_sync_s;
    rise_s = s_sync_s & ~prev_q & mode_q;
    if (wr_clear_s) begin
      clr_s = Din[NSRC-1:0];
    end else begin
      clr_s = '0;
    end
    clr_s = clr_s | (claim_onehot_s & mode_q);
    if (wr_mode_s) begin
      mode_chg_s = Din[NSRC-1:0] ^ mode_q;
      mode_d     = Din[NSRC-1:0];
    end else begin
      mode_chg_s = '0;
      mode_d     = mode_q;
    end
    if (wr_mask_s) begin
      mask_d = Din[NSRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    edge_pend_d = ((edge_pend_q & ~clr_s) | rise_s) & ~mode_chg_s;
    insvc_d     = (insvc_q & ~eoi_onehot_s) | claim_onehot_s;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q      <= '0;
      edge_pend_q <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      insvc_q     <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q      <= prev_d;
      edge_pend_q <= edge_pend_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      insvc_q     <= insvc_d;
    end
  end

  // Read mux; write-only and undefined offsets read as zero.
  always_comb begin
    case (offset_s)
      OFF_PENDING: Dout = {{(32-NSRC){1'b0}}, pending_s};
      OFF_MASK:    Dout = {{(32-NSRC){1'b0}}, mask_q};
      OFF_MODE:    Dout = {{(32-NSRC){1'b0}}, mode_q};
      OFF_CLAIM:   Dout = {claim_valid_s, 28'd0, claim_id_s};
      OFF_INSVC:   Dout = {{(32-NSRC){1'b0}}, insvc_q};
      default:     Dout = 32'd0;
    endcase
  end

  assign HWInt = hwint_s;
  assign irq   = claim_valid_s;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: reset, edge/level latching, claim/EOI nesting,
// same-edge corner cases and asynchronous reset.
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic        we;
  logic        re;
  logic [29:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  src;
  logic [5:0]  hwint;
  logic        irq;
  logic [31:0] rdata;
  int          n_cmp;
  int          n_bad;

  int_ctrl #(.NSRC(6), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .WE    (we),
    .RE    (re),
    .Addr  (addr),
    .Din   (din),
    .Dout  (dout),
    .src   (src),
    .HWInt (hwint),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    addr = {27'd0, off};
    din  = data;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    din  = 32'd0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] data);
    addr = {27'd0, off};
    #1;
    data = dout;
  endtask

  task automatic claim(output logic [31:0] data);
    addr = {27'd0, 3'd4};
    re   = 1'b1;
    #1;
    data = dout;
    @(negedge clk);
    re   = 1'b0;
  endtask

  // One-cycle pulse, then wait until an edge-mode request has been latched.
  task automatic pulse(input logic [5:0] bits);
    src = src | bits;
    cyc(1);
    src = src & ~bits;
    cyc(2);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    we    = 1'b0;
    re    = 1'b0;
    addr  = 30'd0;
    din   = 32'd0;
    src   = 6'd0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Reset sanity
    for (int k = 0; k < 7; k++) begin
      rd(3'(k), rdata);
      chk_eq($sformatf("reset_dout_%0d", k), rdata, 32'd0);
    end
    chk_eq("reset_hwint", {26'd0, hwint}, 32'd0);
    chk_eq("reset_irq", {31'd0, irq}, 32'd0);

    // Edge latency and clear
    wr(3'd2, 32'h0000_003F);
    wr(3'd1, 32'h0000_0001);
    src = 6'h01;
    cyc(1);
    src = 6'h00;
    rd(3'd0, rdata);
    chk_eq("edge_pend_k", rdata, 32'd0);
    cyc(1);
    rd(3'd0, rdata);
    chk_eq("edge_pend_k1", rdata, 32'd0);
    cyc(1);
    rd(3'd0, rdata);
    chk_eq("edge_pend_k2", rdata, 32'h0000_0001);
    cyc(2);
    rd(3'd0, rdata);
    chk_eq("edge_pend_held", rdata, 32'h0000_0001);
    chk_eq("edge_hwint", {26'd0, hwint}, 32'h0000_0001);
    chk_eq("edge_irq", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h0000_0001);
    rd(3'd0, rdata);
    chk_eq("edge_cleared", rdata, 32'd0);
    chk_eq("edge_hwint_cleared", {26'd0, hwint}, 32'd0);

    // Level mode
    wr(3'd2, 32'h0000_0000);
    wr(3'd1, 32'h0000_0004);
    src = 6'h04;
    cyc(1);
    rd(3'd0, rdata);
    chk_eq("level_pend_1edge", rdata, 32'd0);
    cyc(1);
    rd(3'd0, rdata);
    chk_eq("level_pend_2edge", rdata, 32'h0000_0004);
    chk_eq("level_hwint", {26'd0, hwint}, 32'h0000_0004);
    wr(3'd3, 32'h0000_0004);
    rd(3'd0, rdata);
    chk_eq("level_clear_noeffect", rdata, 32'h0000_0004);
    src = 6'h00;
    cyc(1);
    rd(3'd0, rdata);
    chk_eq("level_fall_1edge", rdata, 32'h0000_0004);
    cyc(1);
    rd(3'd0, rdata);
    chk_eq("level_fall_2edge", rdata, 32'd0);

    // Claim, priority, nesting
    wr(3'd2, 32'h0000_003F);
    wr(3'd1, 32'h0000_003F);
    pulse(6'h28);
    rd(3'd0, rdata);
    chk_eq("nest_pend", rdata, 32'h0000_0028);
    chk_eq("nest_hwint0", {26'd0, hwint}, 32'h0000_0028);
    claim(rdata);
    chk_eq("claim3", rdata, 32'h8000_0003);
    rd(3'd6, rdata);
    chk_eq("insvc_08", rdata, 32'h0000_0008);
    rd(3'd0, rdata);
    chk_eq("claim3_pend", rdata, 32'h0000_0020);
    chk_eq("hwint_blocked", {26'd0, hwint}, 32'd0);
    pulse(6'h02);
    chk_eq("hwint_preempt", {26'd0, hwint}, 32'h0000_0002);
    claim(rdata);
    chk_eq("claim1", rdata, 32'h8000_0001);
    rd(3'd6, rdata);
    chk_eq("insvc_0a", rdata, 32'h0000_000A);
    chk_eq("hwint_nested", {26'd0, hwint}, 32'd0);
    wr(3'd5, 32'd1);
    rd(3'd6, rdata);
    chk_eq("eoi1_insvc", rdata, 32'h0000_0008);
    chk_eq("eoi1_hwint", {26'd0, hwint}, 32'd0);
    wr(3'd5, 32'd3);
    rd(3'd6, rdata);
    chk_eq("eoi3_insvc", rdata, 32'd0);
    chk_eq("eoi3_hwint", {26'd0, hwint}, 32'h0000_0020);
    claim(rdata);
    chk_eq("claim5", rdata, 32'h8000_0005);
    wr(3'd5, 32'd5);
    rd(3'd6, rdata);
    chk_eq("eoi5_insvc", rdata, 32'd0);

    // Same-edge CLEAR and new rising edge: set wins
    src = 6'h10;
    cyc(2);
    wr(3'd3, 32'h0000_0010);
    rd(3'd0, rdata);
    chk_eq("clr_vs_set", rdata, 32'h0000_0010);
    wr(3'd3, 32'h0000_0010);
    cyc(2);
    rd(3'd0, rdata);
    chk_eq("held_no_reset", rdata, 32'd0);
    src = 6'h00;
    cyc(2);

    // Build nested state, then invalid claim and out-of-range EOI
    pulse(6'h08);
    claim(rdata);
    chk_eq("claim3_again", rdata, 32'h8000_0003);
    pulse(6'h02);
    claim(rdata);
    chk_eq("claim1_again", rdata, 32'h8000_0001);
    pulse(6'h30);
    rd(3'd0, rdata);
    chk_eq("pend_30", rdata, 32'h0000_0030);
    chk_eq("hwint_all_blocked", {26'd0, hwint}, 32'd0);
    claim(rdata);
    chk_eq("claim_invalid", rdata, 32'd0);
    rd(3'd6, rdata);
    chk_eq("invalid_claim_insvc", rdata, 32'h0000_000A);
    wr(3'd5, 32'd7);
    rd(3'd6, rdata);
    chk_eq("eoi7_insvc", rdata, 32'h0000_000A);

    // Asynchronous reset between edges
    #1;
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      rd(3'(k), rdata);
      chk_eq($sformatf("async_rst_dout_%0d", k), rdata, 32'd0);
    end
    chk_eq("async_rst_hwint", {26'd0, hwint}, 32'd0);
    chk_eq("async_rst_irq", {31'd0, irq}, 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(3);
    rd(3'd0, rdata);
    chk_eq("post_rst_pend", rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
